mult4_seq_ctrl: RTL and testbench
=================================

Name: mult4_seq_ctrl

Overview:
- Sequential shift-and-add multiplier controller: accepts an unsigned WIDTH-bit a×b request and produces the 2·WIDTH-bit product.
- One shared 2·WIDTH-bit adder is reused over WIDTH iterations, instead of a full combinational array.
- Sits beside the combinational multiplier_4bit as its area-reduced, multi-cycle alternative.
- Result is bit-exact to multiplier_4bit for every input pair.

Parameters:
- WIDTH, 4, operand width in bits. Product width is 2*WIDTH.
- CNT_W, 2, iteration counter width. Must equal clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request strobe, sampled on the rising edge.
- a  input  WIDTH  multiplicand, captured when start is accepted.
- b  input  WIDTH  multiplier, captured when start is accepted.
- busy  output  1  high while iterating. A request is accepted only when busy=0.
- done  output  1  one-cycle pulse when product is valid.
- product  output  2*WIDTH  registered result, held until the next done.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, product=0, internal mcand/mplier/acc/cnt=0.
- Reset asserted mid-operation aborts the operation. No done is issued; product returns to 0.
- FSM states: IDLE, CALC, DONE.
- IDLE, start=1 at an edge:
  - mcand <= zero-extended a; mplier <= b; acc <= 0; cnt <= 0.
  - Go to CALC.
- IDLE, start=0: stay in IDLE.
- CALC, each edge:
  - sum = acc + (mplier[0] ? mcand : 0), computed with the shared 2*WIDTH-bit adder. The carry-out is discarded; it cannot overflow.
  - acc <= sum; mcand <= mcand<<1; mplier <= mplier>>1; cnt <= cnt+1.
- CALC, edge where cnt==WIDTH-1:
  - Perform the iteration above and also load product <= sum.
  - Go to DONE.
- DONE lasts one cycle, with done=1 and busy=0.
  - start=1 in DONE: accepted exactly as in IDLE, so back-to-back operation is allowed.
  - Otherwise return to IDLE.
- busy=1 exactly while state==CALC. done=1 exactly while state==DONE. Both are decoded from registered state.
- Latency: start accepted at edge E gives done=1 and a valid product in the cycle after edge E+WIDTH. For WIDTH=4 that is 5 cycles from the start edge to done.
- Throughput: one result per WIDTH+1 cycles.
- start while busy=1 is ignored. Operands are not re-captured and the in-flight result is unaffected.
- a or b changing after acceptance has no effect on the in-flight result.
- product changes only at the CALC→DONE edge or on reset. It is stable at all other times.
- Zero operands: the same fixed latency applies. There is no early termination.

Decomposition:
- Shared include mult_ctrl_defs holds:
  - state encoding localparams: ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2.
  - the default WIDTH/CNT_W values.
- One sub-module, mult_addsub_dp, holds the 2*WIDTH-bit conditional adder plus the shift registers (mcand, mplier, acc).
- The FSM, counter and output registers stay in mult4_seq_ctrl.

Test Plan:
- Reset: assert rst_n=0 mid-CALC (a=9, b=7) → busy=0, done=0, product=0 immediately, with no done pulse afterwards.
- Basic: a=15, b=15, one-cycle start → busy high for 4 cycles, then done pulses once with product=225 (8'hE1).
- Zero/identity: a=0, b=13 → product=0; a=1, b=13 → product=13. Both take exactly 5 cycles from the start edge to done.
- Ignore while busy: a=6, b=5 started, then start=1 with a=15, b=15 during CALC → product=30, with only one done pulse.
- Back-to-back: start held high with a=3, b=4 then a=12, b=11 → done pulses 5 cycles apart, product=12 then 132. The product stays 12 between the two pulses.
- Exhaustive: all 256 (a,b) pairs sequenced → every product equals a*b, and done is never asserted while busy=1.

Source files
------------

// File: rtl/mult4_seq_ctrl_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encodings and default operand/counter widths.
package mult4_seq_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 2;

endpackage

// File: rtl/mult_addsub_dp.sv
// Shift-and-add datapath: one shared 2*WIDTH-bit conditional adder plus the
// multiplicand, multiplier and accumulator shift registers.
module mult_addsub_dp #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   sum
);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;

    // Product of two WIDTH-bit values fits in 2*WIDTH bits, so the carry-out is dropped.
    assign sum = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (load) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
        end else if (step) begin
            acc    <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/mult4_seq_ctrl.sv
// Sequential shift-and-add multiplier controller: FSM, iteration counter and
// registered product around the shared-adder datapath.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; operands captured when start is seen
// CALC    | one add/shift iteration per cycle, WIDTH cycles total
// DONE    | one-cycle done pulse; a new start is accepted here too
module mult4_seq_ctrl
    import mult4_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] sum;
    logic               accept;
    logic               calc;
    logic               last_iter;

    assign calc      = (state == ST_CALC);
    assign accept    = start && !calc;
    assign last_iter = calc && (cnt == CNT_W'(WIDTH - 1));

    assign busy = calc;
    assign done = (state == ST_DONE);

    mult_addsub_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .step  (calc),
        .a     (a),
        .b     (b),
        .sum   (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                ST_CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        product <= sum;
                        state   <= ST_DONE;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        cnt   <= '0;
                        state <= ST_CALC;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult4_seq_ctrl.sv
// Directed self-checking bench for mult4_seq_ctrl (WIDTH=4).
module tb_mult4_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int n_chk  = 0;
    int n_fail = 0;

    mult4_seq_ctrl #(.WIDTH(4), .CNT_W(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a one-cycle start, then waits (bounded) for done.
    // lat counts cycles from the start edge; -1 means done never came.
    task automatic run_op(input logic [3:0] ia, input logic [3:0] ib,
                          output int lat, output int busy_cyc,
                          output int overlap, output logic [7:0] prod);
        a = ia;
        b = ib;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        busy_cyc = 0;
        overlap = 0;
        prod = 'x;
        while (lat <= 20 && !done) begin
            if (busy) busy_cyc++;
            tick();
            lat++;
        end
        if (done) begin
            prod = product;
            if (busy) overlap++;
        end else begin
            lat = -1;
        end
    endtask

    task automatic test_reset();
        int extra_done;
        rst_n = 1'b0;
        #3;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_chk++; if (product !== 8'd0) begin n_fail++; $display("FAIL reset_product got %0d want 0", product); end
        tick();
        rst_n = 1'b1;
        tick();
        a = 4'd9; b = 4'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midcalc_busy got %b want 1", busy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got %b want 0", done); end
        n_chk++; if (product !== 8'd0) begin n_fail++; $display("FAIL abort_product got %0d want 0", product); end
        tick();
        rst_n = 1'b1;
        extra_done = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) extra_done++;
        end
        n_chk++; if (extra_done !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d pulses want 0", extra_done); end
    endtask

    task automatic test_basic();
        int lat, bc, ov;
        logic [7:0] p;
        run_op(4'd15, 4'd15, lat, bc, ov, p);
        n_chk++; if (p !== 8'hE1) begin n_fail++; $display("FAIL basic_product got %0d want 225", p); end
        n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL basic_latency got %0d want 5", lat); end
        n_chk++; if (bc !== 4) begin n_fail++; $display("FAIL basic_busy_cycles got %0d want 4", bc); end
        n_chk++; if (ov !== 0) begin n_fail++; $display("FAIL basic_done_busy_overlap got %0d want 0", ov); end
        tick();
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_one_cycle got %b want 0", done); end
        n_chk++; if (product !== 8'hE1) begin n_fail++; $display("FAIL basic_product_hold got %0d want 225", product); end
    endtask

    task automatic test_zero_identity();
        int lat, bc, ov;
        logic [7:0] p;
        run_op(4'd0, 4'd13, lat, bc, ov, p);
        n_chk++; if (p !== 8'd0) begin n_fail++; $display("FAIL zero_product got %0d want 0", p); end
        n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL zero_latency got %0d want 5", lat); end
        tick();
        run_op(4'd1, 4'd13, lat, bc, ov, p);
        n_chk++; if (p !== 8'd13) begin n_fail++; $display("FAIL ident_product got %0d want 13", p); end
        n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL ident_latency got %0d want 5", lat); end
        tick();
    endtask

    task automatic test_ignore_busy();
        int n_done;
        logic [7:0] p;
        a = 4'd6; b = 4'd5; start = 1'b1;
        tick();
        a = 4'd15; b = 4'd15;
        tick();
        tick();
        start = 1'b0;
        a = 4'd2; b = 4'd3;
        n_done = 0;
        p = 'x;
        for (int i = 0; i < 12; i++) begin
            if (done) begin n_done++; p = product; end
            tick();
        end
        n_chk++; if (p !== 8'd30) begin n_fail++; $display("FAIL ignore_product got %0d want 30", p); end
        n_chk++; if (n_done !== 1) begin n_fail++; $display("FAIL ignore_done_count got %0d want 1", n_done); end
    endtask

    task automatic test_back_to_back();
        int d1, d2, hold_bad;
        logic [7:0] p1, p2;
        d1 = -1; d2 = -1; hold_bad = 0;
        p1 = 'x; p2 = 'x;
        a = 4'd3; b = 4'd4; start = 1'b1;
        tick();
        a = 4'd12; b = 4'd11;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            if (cyc == 6) start = 1'b0;
            if (done) begin
                if (d1 < 0) begin d1 = cyc; p1 = product; end
                else if (d2 < 0) begin d2 = cyc; p2 = product; end
            end
            if (cyc >= 6 && cyc <= 9 && product !== 8'd12) hold_bad++;
            tick();
        end
        n_chk++; if (d1 !== 5) begin n_fail++; $display("FAIL b2b_first_done got cycle %0d want 5", d1); end
        n_chk++; if (p1 !== 8'd12) begin n_fail++; $display("FAIL b2b_first_product got %0d want 12", p1); end
        n_chk++; if (d2 !== 10) begin n_fail++; $display("FAIL b2b_second_done got cycle %0d want 10", d2); end
        n_chk++; if (p2 !== 8'd132) begin n_fail++; $display("FAIL b2b_second_product got %0d want 132", p2); end
        n_chk++; if (hold_bad !== 0) begin n_fail++; $display("FAIL b2b_product_hold got %0d bad cycles want 0", hold_bad); end
    endtask

    task automatic test_exhaustive();
        int lat, bc, ov;
        logic [7:0] p, exp_p;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                exp_p = 8'(ia * ib);
                run_op(4'(ia), 4'(ib), lat, bc, ov, p);
                n_chk++;
                if (p !== exp_p || lat !== 5 || ov !== 0) begin
                    n_fail++;
                    $display("FAIL exh_%0dx%0d got product %0d lat %0d overlap %0d want %0d lat 5 overlap 0",
                             ia, ib, p, lat, ov, exp_p);
                end
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_identity();
        test_ignore_busy();
        test_back_to_back();
        test_exhaustive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
